midi_note_tx: RTL and testbench
===============================

MIDI_NOTE_TX -- requirements
Module: midi_note_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 31250, MIDI serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division, minimum 4.
REQ-003 The block SHALL have parameter RUNNING_STATUS, default 0, where 1 enables MIDI running-status byte suppression.
REQ-004 The block SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid  input  1  note event request.
REQ-007 The block SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-008 The block SHALL have port req_offset  input  5  key offset from C3 (pitch 48); legal range 0..23.
REQ-009 The block SHALL have port req_note_on  input  1  1 = Note On, 0 = Note Off.
REQ-010 The block SHALL have port req_channel  input  4  MIDI channel 0..15.
REQ-011 The block SHALL have port req_velocity  input  7  velocity for Note On; ignored for Note Off.
REQ-012 The block SHALL have port tx  output  1  MIDI serial line, idle high.
REQ-013 The block SHALL have port busy  output  1  message in progress.
REQ-014 The block SHALL have port err_range  output  1  one-cycle pulse on a rejected out-of-range request.

Function
REQ-015 Accept SHALL occur on any cycle with req_valid=1 and req_ready=1; req_ready SHALL be 1 exactly when the state is IDLE; busy SHALL equal !req_ready.
REQ-016 On accept with req_offset>23: no transmission; err_range=1 for the following cycle only; state stays IDLE; req_ready stays 1; running-status memory unchanged.
REQ-017 On accept with req_offset<=23, all inputs SHALL be latched; status = {1001,channel} for Note On, {1000,channel} for Note Off; byte1 = req_offset+48 (8-bit, MSB 0); byte2 = {0,velocity} for Note On, 8'h40 for Note Off.
REQ-018 If RUNNING_STATUS=1 and the status byte equals the last transmitted status, the status byte SHALL be skipped (2-byte message); otherwise 3 bytes are sent; last status is updated on every legal accept.
REQ-019 Byte sequencer states: IDLE, START, DATA, STOP; a byte index (0..2) selects the current byte; after STOP of the last byte go to IDLE, otherwise go to START of the next byte with no idle gap.
REQ-020 Each byte frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit SHALL be held exactly CLKS_PER_BIT cycles, timed by a bit counter reset on every bit boundary.
REQ-021 Latency: tx SHALL go low on the cycle after accept; message duration SHALL be exactly N*10*CLKS_PER_BIT cycles (N = 2 or 3); req_ready SHALL return to 1 on the cycle after the last stop bit completes.
REQ-022 req_valid while busy SHALL be ignored; no request is queued.
REQ-023 A changing req_* input during transmission SHALL NOT alter the bytes being sent.

Reset
REQ-024 reset=1 SHALL, on the next rising edge, force: state IDLE, tx=1, req_ready=1, busy=0, err_range=0, counters 0, running-status memory invalid (the next message always sends status).
REQ-025 Reset asserted mid-frame SHALL abort the message immediately; no partial bytes resume after reset deasserts.

Verification (CLK_FREQ=312500, BAUD=31250 -> 10 clk/bit)
REQ-026 Note On offset=12, ch=0, vel=100 -> tx frames 0x90,0x3C,0x64; 300 cycles busy; each bit 10 cycles; ready returns the cycle after.
REQ-027 Note Off offset=0, ch=5 -> bytes 0x85,0x30,0x40; velocity input ignored.
REQ-028 offset=24 with valid -> err_range pulses 1 cycle, tx stays 1, ready stays 1; offset=31 gives the same result.
REQ-029 RUNNING_STATUS=1: two Note On ch 3 back-to-back (offsets 2, 4) -> 0x93,0x32,vel then 0x34,vel (200 cycles); after reset the same event resends 0x93.
REQ-030 Reset asserted 55 cycles into a message -> tx=1 the next cycle, ready=1, no further frame edges; a new request then transmits cleanly.
REQ-031 req_valid held high continuously -> accepts only when ready, with no lost or duplicated frames, and a start bit immediately follows the ready cycle.

Source files
------------

// File: rtl/midi_note_tx.sv
// MIDI Note On/Off transmitter: latches a key event, builds a 2- or 3-byte
// MIDI message and shifts it out as 8N1 frames at the configured baud rate.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for a request, line idle high
// S_START | driving the start bit (0) of byte idx_q
// S_DATA  | driving data bit bit_q of byte idx_q, LSB first
// S_STOP  | driving the stop bit (1) of byte idx_q
module midi_note_tx #(
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD           = 31250,
  parameter int RUNNING_STATUS = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_offset,
  input  logic       req_note_on,
  input  logic [3:0] req_channel,
  input  logic [6:0] req_velocity,
  output logic       tx,
  output logic       busy,
  output logic       err_range
);

  localparam int CPB_RAW = CLK_FREQ / BAUD;
  localparam int CPB     = (CPB_RAW < 4) ? 4 : CPB_RAW;
  localparam int CW      = $clog2(CPB);
  localparam logic [CW-1:0] BIT_LOAD = CW'(CPB - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      byte0_q, byte0_d;
  logic [7:0]      byte1_q, byte1_d;
  logic [7:0]      byte2_q, byte2_d;
  logic [7:0]      last_status_q, last_status_d;
  logic            last_valid_q, last_valid_d;
  logic            err_q, err_d;

  logic            accept;
  logic            legal;
  logic            skip;
  logic            bit_done;
  logic [7:0]      status;
  logic [7:0]      cur_byte;

  assign accept   = req_valid && (state_q == S_IDLE);
  assign legal    = (req_offset <= 5'd23);
  assign status   = {(req_note_on ? 4'b1001 : 4'b1000), req_channel};
  assign skip     = (RUNNING_STATUS != 0) && last_valid_q && (status == last_status_q);
  assign bit_done = (cnt_q == '0);

  always_comb begin
    case (idx_q)
      2'd0:    cur_byte = byte0_q;
      2'd1:    cur_byte = byte1_q;
      default: cur_byte = byte2_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    idx_d         = idx_q;
    byte0_d       = byte0_q;
    byte1_d       = byte1_q;
    byte2_d       = byte2_q;
    last_status_d = last_status_q;
    last_valid_d  = last_valid_q;
    err_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (legal) begin
            byte0_d       = status;
            byte1_d       = {3'b000, req_offset} + 8'd48;
            byte2_d       = req_note_on ? {1'b0, req_velocity} : 8'h40;
            idx_d         = skip ? 2'd1 : 2'd0;
            bit_d         = 3'd0;
            cnt_d         = BIT_LOAD;
            state_d       = S_START;
            last_status_d = status;
            last_valid_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_START: begin
        if (bit_done) begin
          cnt_d   = BIT_LOAD;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d = BIT_LOAD;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (idx_q == 2'd2) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = BIT_LOAD;
            idx_d   = idx_q + 2'd1;
            state_d = S_START;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= 3'd0;
      idx_q         <= 2'd0;
      byte0_q       <= 8'h00;
      byte1_q       <= 8'h00;
      byte2_q       <= 8'h00;
      last_status_q <= 8'h00;
      last_valid_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      idx_q         <= idx_d;
      byte0_q       <= byte0_d;
      byte1_q       <= byte1_d;
      byte2_q       <= byte2_d;
      last_status_q <= last_status_d;
      last_valid_q  <= last_valid_d;
      err_q         <= err_d;
    end
  end

  // Line level decodes straight from registered state, so it tracks state exactly.
  always_comb begin
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = cur_byte[bit_q];
      default: tx = 1'b1;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = !req_ready;
  assign err_range = err_q;

endmodule

// File: tb/tb_midi_note_tx.sv
// Directed bench for midi_note_tx at 10 clocks per bit, one instance without
// and one with running status, sharing clock, reset and request inputs.
module tb_midi_note_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [4:0] req_offset = 5'd0;
  logic       req_note_on = 1'b0;
  logic [3:0] req_channel = 4'd0;
  logic [6:0] req_velocity = 7'd0;

  logic tx0, rdy0, busy0, err0;
  logic tx1, rdy1, busy1, err1;

  int total = 0;
  int bad   = 0;

  midi_note_tx #(.CLK_FREQ(312500), .BAUD(31250), .RUNNING_STATUS(0)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy0),
    .req_offset(req_offset), .req_note_on(req_note_on), .req_channel(req_channel),
    .req_velocity(req_velocity), .tx(tx0), .busy(busy0), .err_range(err0)
  );

  midi_note_tx #(.CLK_FREQ(312500), .BAUD(31250), .RUNNING_STATUS(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
    .req_offset(req_offset), .req_note_on(req_note_on), .req_channel(req_channel),
    .req_velocity(req_velocity), .tx(tx1), .busy(busy1), .err_range(err1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Presents a request for exactly one cycle; returns one cycle after the accept edge.
  task automatic issue(input logic on, input logic [4:0] off, input logic [3:0] ch,
                       input logic [6:0] vel);
    req_note_on  = on;
    req_offset   = off;
    req_channel  = ch;
    req_velocity = vel;
    req_valid    = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Starts at the first cycle after accept and ends on the cycle ready returns.
  task automatic check_msg(input bit sel, input logic [7:0] m0, input logic [7:0] m1,
                           input logic [7:0] m2, input int n, input string name,
                           input bit scramble);
    logic [7:0] bt;
    int bi, bb;
    logic expb, ts, rs, bs, es;
    bit seen;
    seen = 1'b0;
    total++;
    for (int k = 0; k < n * 100; k++) begin
      bi = k / 100;
      bb = (k % 100) / 10;
      bt = (bi == 0) ? m0 : ((bi == 1) ? m1 : m2);
      expb = (bb == 0) ? 1'b0 : ((bb == 9) ? 1'b1 : bt[bb-1]);
      ts = sel ? tx1 : tx0;
      rs = sel ? rdy1 : rdy0;
      bs = sel ? busy1 : busy0;
      es = sel ? err1 : err0;
      if (!seen && (ts !== expb || rs !== 1'b0 || bs !== 1'b1 || es !== 1'b0)) begin
        seen = 1'b1;
        bad++;
        $display("FAIL %s: cycle %0d got tx=%b ready=%b busy=%b err=%b, required tx=%b ready=0 busy=1 err=0",
                 name, k, ts, rs, bs, es, expb);
      end
      if (scramble) begin
        req_offset   = 5'($urandom_range(0, 31));
        req_channel  = 4'($urandom_range(0, 15));
        req_velocity = 7'($urandom_range(0, 127));
        req_note_on  = 1'($urandom_range(0, 1));
        req_valid    = (k < n * 100 - 1);
      end
      tick();
    end
    ts = sel ? tx1 : tx0;
    rs = sel ? rdy1 : rdy0;
    bs = sel ? busy1 : busy0;
    total++;
    if (ts !== 1'b1 || rs !== 1'b1 || bs !== 1'b0) begin
      bad++;
      $display("FAIL %s_end: got tx=%b ready=%b busy=%b, required tx=1 ready=1 busy=0",
               name, ts, rs, bs);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b1;
    repeat (3) tick();
    req_valid = 1'b0;
    total++;
    if ({tx0, rdy0, busy0, err0} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_u0: got tx,ready,busy,err=%b required 1100", {tx0, rdy0, busy0, err0});
    end
    total++;
    if ({tx1, rdy1, busy1, err1} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_u1: got tx,ready,busy,err=%b required 1100", {tx1, rdy1, busy1, err1});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_note_on;
    issue(1'b1, 5'd12, 4'd0, 7'd100);
    check_msg(1'b0, 8'h90, 8'h3C, 8'h64, 3, "note_on", 1'b0);
  endtask

  task automatic test_note_off;
    issue(1'b0, 5'd0, 4'd5, 7'h7F);
    check_msg(1'b0, 8'h85, 8'h30, 8'h40, 3, "note_off", 1'b0);
  endtask

  task automatic test_top_key;
    issue(1'b1, 5'd23, 4'd15, 7'd0);
    check_msg(1'b0, 8'h9F, 8'h47, 8'h00, 3, "top_key", 1'b0);
  endtask

  task automatic test_range;
    logic [4:0] offs [2];
    offs[0] = 5'd24;
    offs[1] = 5'd31;
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, offs[i], 4'd2, 7'd10);
      total++;
      if ({err0, tx0, rdy0, busy0} !== 4'b1110) begin
        bad++;
        $display("FAIL range_pulse off=%0d: got err,tx,ready,busy=%b required 1110",
                 offs[i], {err0, tx0, rdy0, busy0});
      end
      tick();
      total++;
      if ({err0, tx0, rdy0, busy0} !== 4'b0110) begin
        bad++;
        $display("FAIL range_after off=%0d: got err,tx,ready,busy=%b required 0110",
                 offs[i], {err0, tx0, rdy0, busy0});
      end
    end
  endtask

  task automatic test_ignore_busy;
    issue(1'b1, 5'd5, 4'd1, 7'd64);
    check_msg(1'b0, 8'h91, 8'h35, 8'h40, 3, "ignore_busy", 1'b1);
    tick();
    total++;
    if (rdy0 !== 1'b1 || tx0 !== 1'b1) begin
      bad++;
      $display("FAIL ignore_no_queue: got ready=%b tx=%b required ready=1 tx=1", rdy0, tx0);
    end
  endtask

  task automatic test_back_to_back;
    req_note_on  = 1'b1;
    req_offset   = 5'd7;
    req_channel  = 4'd9;
    req_velocity = 7'h11;
    req_valid    = 1'b1;
    tick();
    check_msg(1'b0, 8'h99, 8'h37, 8'h11, 3, "b2b_first", 1'b0);
    tick();
    req_valid = 1'b0;
    check_msg(1'b0, 8'h99, 8'h37, 8'h11, 3, "b2b_second", 1'b0);
    tick();
    total++;
    if (rdy0 !== 1'b1 || tx0 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_no_dup: got ready=%b tx=%b required ready=1 tx=1", rdy0, tx0);
    end
  endtask

  task automatic test_running_status;
    pulse_reset();
    issue(1'b1, 5'd2, 4'd3, 7'h55);
    check_msg(1'b1, 8'h93, 8'h32, 8'h55, 3, "rs_first", 1'b0);
    issue(1'b1, 5'd30, 4'd7, 7'd1);
    total++;
    if (err1 !== 1'b1 || rdy1 !== 1'b1) begin
      bad++;
      $display("FAIL rs_err: got err=%b ready=%b required err=1 ready=1", err1, rdy1);
    end
    issue(1'b1, 5'd4, 4'd3, 7'h55);
    check_msg(1'b1, 8'h34, 8'h55, 8'h00, 2, "rs_skip", 1'b0);
    pulse_reset();
    issue(1'b1, 5'd4, 4'd3, 7'h55);
    check_msg(1'b1, 8'h93, 8'h34, 8'h55, 3, "rs_after_reset", 1'b0);
  endtask

  task automatic test_reset_mid;
    bit seen;
    pulse_reset();
    issue(1'b1, 5'd12, 4'd0, 7'd100);
    repeat (55) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({tx0, rdy0, busy0} !== 3'b110) begin
      bad++;
      $display("FAIL mid_reset: got tx,ready,busy=%b required 110", {tx0, rdy0, busy0});
    end
    seen = 1'b0;
    total++;
    for (int k = 0; k < 300; k++) begin
      if (!seen && (tx0 !== 1'b1 || rdy0 !== 1'b1)) begin
        seen = 1'b1;
        bad++;
        $display("FAIL mid_reset_quiet: cycle %0d got tx=%b ready=%b required tx=1 ready=1", k, tx0, rdy0);
      end
      tick();
    end
    issue(1'b0, 5'd1, 4'd2, 7'd0);
    check_msg(1'b0, 8'h82, 8'h31, 8'h40, 3, "after_mid_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_note_off();
    test_top_key();
    test_range();
    test_ignore_busy();
    test_back_to_back();
    test_running_status();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
